// File: rtl/bus_slave_responder.sv
// Serial bus slave: receives a bit-serial address/burst header, optionally
// splits for a programmable number of cycles, then writes or reads a burst of
// words to/from a small internal memory, one bit per handshake.
module bus_slave_responder #(
  parameter int unsigned ADDR_LEN  = 12,
  parameter int unsigned BURST_LEN = 12,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned MEM_AW    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  logic       read_en,
  input  logic       m_valid,
  input  logic       m_ready,
  input  logic       rx_address,
  input  logic       rx_burst,
  input  logic       rx_data,
  input  logic [5:0] slave_delay,
  output logic       tx_data,
  output logic       s_valid,
  output logic       s_ready,
  output logic       split_en
);

  localparam int unsigned MaxLen = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;
  localparam int unsigned Depth  = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSplit,
    StWdata,
    StRdata,
    StDone
  } state_e;

  state_e state_q, state_d;
  state_e data_st;

  // Set on the first clock edge after reset release; holds s_ready low until then.
  logic alive_q;

  // Header shifters keep all but the newest bit; the newest bit comes straight
  // from the serial input so the full field is available in the accepting cycle.
  logic [ADDR_LEN-2:0]  addr_sr_q, addr_sr_d;
  logic [BURST_LEN-2:0] burst_sr_q, burst_sr_d;
  logic [DATA_LEN-2:0]  wr_sr_q, wr_sr_d;
  logic [DATA_LEN-1:0]  tx_sr_q, tx_sr_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [5:0]           delay_cnt_q, delay_cnt_d;
  logic [MEM_AW-1:0]    ptr_q, ptr_d;
  logic [BURST_LEN-1:0] words_left_q, words_left_d;

  logic [DATA_LEN-1:0] mem_q [Depth];
  logic                mem_we;

  logic [ADDR_LEN-1:0]  addr_full;
  logic [BURST_LEN-1:0] burst_full;
  logic [DATA_LEN-1:0]  wr_word;

  logic accept_in;
  logic accept_out;
  logic go;
  logic abort;
  logic bit_last_addr;
  logic bit_last_data;
  logic last_word;
  logic rd_word_done;

  assign addr_full  = {rx_address, addr_sr_q};
  assign burst_full = {rx_burst, burst_sr_q};
  assign wr_word    = {rx_data, wr_sr_q};

  assign accept_in     = m_valid & s_ready;
  assign accept_out    = s_valid & m_ready;
  assign go            = accept_in & (write_en | read_en);
  assign abort         = (state_q != StIdle) & ~write_en & ~read_en;
  assign bit_last_addr = (bit_cnt_q == CntW'(ADDR_LEN - 1));
  assign bit_last_data = (bit_cnt_q == CntW'(DATA_LEN - 1));
  assign last_word     = (words_left_q == BURST_LEN'(1));

  // State register and reset-release flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic; a dropped request aborts from any busy state.
  always_comb begin
    state_d = state_q;
    data_st = write_en ? StWdata : StRdata;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = StAddr;
      end
      StAddr: begin
        if (accept_in && bit_last_addr) begin
          state_d = (slave_delay != 6'd0) ? StSplit : data_st;
        end
      end
      StSplit: begin
        if (delay_cnt_q <= 6'd1) state_d = data_st;
      end
      StWdata: begin
        if (accept_in && bit_last_data && last_word) state_d = StDone;
      end
      StRdata: begin
        if (accept_out && bit_last_data && last_word) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort) state_d = StIdle;
  end

  // Outputs decoded from the current state.
  always_comb begin
    s_ready  = 1'b0;
    s_valid  = 1'b0;
    split_en = 1'b0;
    tx_data  = 1'b0;
    unique case (state_q)
      StIdle, StAddr, StWdata: s_ready = alive_q;
      StSplit:                 split_en = 1'b1;
      StRdata: begin
        s_valid = 1'b1;
        tx_data = tx_sr_q[0];
      end
      default: ;
    endcase
  end

  // Datapath next-state: header capture, delay count, word shifting, addressing.
  always_comb begin
    addr_sr_d    = addr_sr_q;
    burst_sr_d   = burst_sr_q;
    wr_sr_d      = wr_sr_q;
    tx_sr_d      = tx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    delay_cnt_d  = delay_cnt_q;
    ptr_d        = ptr_q;
    words_left_d = words_left_q;
    mem_we       = 1'b0;
    rd_word_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (go) begin
          addr_sr_d  = addr_full[ADDR_LEN-1:1];
          burst_sr_d = burst_full[BURST_LEN-1:1];
          bit_cnt_d  = CntW'(1);
        end
      end
      StAddr: begin
        if (!abort && accept_in) begin
          addr_sr_d  = addr_full[ADDR_LEN-1:1];
          burst_sr_d = burst_full[BURST_LEN-1:1];
          bit_cnt_d  = bit_cnt_q + CntW'(1);
          if (bit_last_addr) begin
            bit_cnt_d    = '0;
            ptr_d        = addr_full[MEM_AW-1:0];
            // A zero burst count still moves one word.
            words_left_d = (burst_full == '0) ? BURST_LEN'(1) : burst_full;
            delay_cnt_d  = slave_delay;
          end
        end
      end
      StSplit: begin
        if (!abort) delay_cnt_d = delay_cnt_q - 6'd1;
      end
      StWdata: begin
        if (!abort && accept_in) begin
          wr_sr_d   = wr_word[DATA_LEN-1:1];
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_last_data) begin
            mem_we       = 1'b1;
            bit_cnt_d    = '0;
            ptr_d        = ptr_q + MEM_AW'(1);
            words_left_d = words_left_q - BURST_LEN'(1);
          end
        end
      end
      StRdata: begin
        if (!abort && accept_out) begin
          tx_sr_d   = tx_sr_q >> 1;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_last_data) begin
            rd_word_done = 1'b1;
            bit_cnt_d    = '0;
            ptr_d        = ptr_q + MEM_AW'(1);
            words_left_d = words_left_q - BURST_LEN'(1);
          end
        end
      end
      default: ;
    endcase

    if (abort) bit_cnt_d = '0;

    // Load the read shifter on entry to RDATA and whenever another word follows.
    if ((state_d == StRdata) && ((state_q != StRdata) || rd_word_done)) begin
      tx_sr_d = mem_q[ptr_d];
    end
  end

  // Datapath registers; all counters and shifters clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_sr_q    <= '0;
      burst_sr_q   <= '0;
      wr_sr_q      <= '0;
      tx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      delay_cnt_q  <= '0;
      ptr_q        <= '0;
      words_left_q <= '0;
    end else begin
      addr_sr_q    <= addr_sr_d;
      burst_sr_q   <= burst_sr_d;
      wr_sr_q      <= wr_sr_d;
      tx_sr_q      <= tx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      delay_cnt_q  <= delay_cnt_d;
      ptr_q        <= ptr_d;
      words_left_q <= words_left_d;
    end
  end

  // Word memory; deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= wr_word;
  end

endmodule

// File: tb/tb_bus_slave_responder.sv
module tb_bus_slave_responder;

  localparam int AL = 12;
  localparam int DL = 8;
  localparam int MemWords = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic       rx_address = 1'b0;
  logic       rx_burst = 1'b0;
  logic       rx_data = 1'b0;
  logic [5:0] slave_delay = 6'd0;
  logic       tx_data;
  logic       s_valid;
  logic       s_ready;
  logic       split_en;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: content plus a flag for locations the bench has written.
  logic [7:0] ref_mem [MemWords];
  bit         ref_vld [MemWords];
  logic [7:0] wbuf [16];

  bus_slave_responder dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .read_en    (read_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .rx_address (rx_address),
    .rx_burst   (rx_burst),
    .rx_data    (rx_data),
    .slave_delay(slave_delay),
    .tx_data    (tx_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .split_en   (split_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nwords(input logic [11:0] burst);
    return (burst == 12'd0) ? 1 : int'(burst);
  endfunction

  function automatic int widx(input logic [11:0] addr, input int w);
    return (int'(addr[5:0]) + w) % MemWords;
  endfunction

  // Header phase; caller has already raised the request line(s).
  task automatic send_addr(input logic [11:0] addr, input logic [11:0] burst, input bit gaps);
    for (int i = 0; i < AL; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        m_valid = 1'b0;
        tick();
      end
      m_valid    = 1'b1;
      rx_address = addr[i];
      rx_burst   = burst[i];
      check("addr_rdy", 32'(s_ready), 32'd1);
      tick();
    end
    m_valid = 1'b0;
  endtask

  task automatic wait_split(input int dly);
    int cnt = 0;
    bit bad = 1'b0;
    while (split_en && cnt < 80) begin
      cnt++;
      if (s_ready || s_valid) bad = 1'b1;
      tick();
    end
    check("split_len", 32'(cnt), 32'(dly));
    check("split_quiet", 32'(bad), 32'd0);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [11:0] burst, input int dly,
                          input bit gaps);
    int nw = nwords(burst);
    slave_delay = 6'(dly);
    write_en    = 1'b1;
    read_en     = 1'($urandom_range(0, 1));
    send_addr(addr, burst, gaps);
    slave_delay = 6'($urandom);
    wait_split(dly);
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < DL; b++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) begin
          m_valid = 1'b0;
          tick();
        end
        m_valid = 1'b1;
        rx_data = wbuf[w][b];
        check("wr_rdy", 32'(s_ready), 32'd1);
        tick();
      end
    end
    m_valid = 1'b0;
    check("wr_done", 32'({s_ready, s_valid, split_en}), 32'd0);
    for (int w = 0; w < nw; w++) begin
      ref_mem[widx(addr, w)] = wbuf[w];
      ref_vld[widx(addr, w)] = 1'b1;
    end
    write_en = 1'b0;
    read_en  = 1'b0;
    tick();
    check("wr_idle", 32'(s_ready), 32'd1);
  endtask

  // bp: 0 = always ready, 1 = toggle ready/not-ready, 2 = random ready.
  task automatic do_read(input logic [11:0] addr, input logic [11:0] burst, input int dly,
                         input int bp, input bit gaps);
    int nw = nwords(burst);
    bit tg = 1'b1;
    slave_delay = 6'(dly);
    write_en    = 1'b0;
    read_en     = 1'b1;
    send_addr(addr, burst, gaps);
    slave_delay = 6'($urandom);
    wait_split(dly);
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < DL; b++) begin
        int  tries = 0;
        logic took = 1'b0;
        while (!took) begin
          case (bp)
            0:       m_ready = 1'b1;
            1:       m_ready = tg;
            default: m_ready = 1'($urandom_range(0, 1));
          endcase
          tg = ~tg;
          if (tries >= 6) m_ready = 1'b1;
          check("rd_vld", 32'(s_valid), 32'd1);
          if (ref_vld[widx(addr, w)]) begin
            check("rd_bit", 32'(tx_data), 32'(ref_mem[widx(addr, w)][b]));
          end
          took = m_ready;
          tick();
          tries++;
        end
      end
    end
    m_ready = 1'b0;
    check("rd_done", 32'({s_ready, s_valid, split_en}), 32'd0);
    read_en = 1'b0;
    tick();
    check("rd_idle", 32'(s_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < MemWords; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 1'b0;
    end

    // Reset behaviour and s_ready release timing.
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'({tx_data, s_valid, split_en, s_ready}), 32'd0);
    rst = 1'b1;
    #1;
    check("rdy_pre_edge", 32'(s_ready), 32'd0);
    tick();
    check("rdy_post_edge", 32'(s_ready), 32'd1);

    // Basic write burst then read back.
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(12'h005, 12'd2, 0, 1'b0);
    do_read(12'h005, 12'd2, 0, 0, 1'b0);

    // Split delay with stalls and backpressure; upper address bits ignored.
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'hC3;
    wbuf[2] = 8'h0F;
    do_write(12'hF4A, 12'd3, 10, 1'b1);
    do_read(12'h04A, 12'd3, 10, 1, 1'b0);

    // Address wrap at the top of memory.
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(12'h03F, 12'd2, 0, 1'b0);
    do_read(12'h03F, 12'd2, 3, 0, 1'b0);
    do_read(12'h000, 12'd1, 0, 0, 1'b0);

    // Zero burst moves exactly one word.
    wbuf[0] = 8'h77;
    wbuf[1] = 8'h99;
    do_write(12'h020, 12'd0, 0, 1'b0);
    do_read(12'h020, 12'd0, 0, 2, 1'b0);

    // Abort after 4 data bits leaves memory untouched.
    wbuf[0] = 8'hE7;
    do_write(12'h010, 12'd1, 0, 1'b0);
    slave_delay = 6'd0;
    write_en    = 1'b1;
    send_addr(12'h010, 12'd1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      m_valid = 1'b1;
      rx_data = 1'b0;
      tick();
    end
    m_valid  = 1'b0;
    write_en = 1'b0;
    tick();
    check("abort_idle", 32'(s_ready), 32'd1);
    do_read(12'h010, 12'd1, 0, 0, 1'b0);

    // Reset in the middle of a read.
    wbuf[0] = 8'h96;
    wbuf[1] = 8'h69;
    do_write(12'h030, 12'd2, 0, 1'b0);
    slave_delay = 6'd0;
    read_en     = 1'b1;
    send_addr(12'h030, 12'd2, 1'b0);
    m_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      check("mid_vld", 32'(s_valid), 32'd1);
      tick();
    end
    rst = 1'b0;
    #1;
    check("rst_mid", 32'({tx_data, s_valid, split_en, s_ready}), 32'd0);
    m_ready = 1'b0;
    read_en = 1'b0;
    tick();
    check("rst_hold", 32'({s_valid, s_ready}), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_rel_pre", 32'(s_ready), 32'd0);
    tick();
    check("rst_rel_post", 32'(s_ready), 32'd1);
    do_read(12'h030, 12'd2, 0, 2, 1'b0);

    // Randomized transactions against the reference memory.
    for (int t = 0; t < 10; t++) begin
      logic [11:0] addr;
      logic [11:0] burst;
      int          dly;
      addr  = 12'($urandom);
      burst = 12'($urandom_range(0, 6));
      dly   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      for (int w = 0; w < 16; w++) wbuf[w] = 8'($urandom);
      do_write(addr, burst, dly, 1'b1);
      do_read(addr, burst, int'($urandom_range(0, 4)), 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case a wait somewhere never resolves.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
